// File: rtl/segment_reader.sv
// Reads back a multiplexed active-low seven-segment bus, debounces each digit and
// delivers the decoded word over valid/ready. SEGMENT_READER_CHANGE_ONLY_EN suppresses repeated frames.
module segment_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [6:0]                segments_ni,
    input  logic [NUM_DIGITS-1:0]     digit_sel_ni,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic [4*NUM_DIGITS-1:0]   value_o,
    output logic [NUM_DIGITS-1:0]     digit_err_o
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0] prev_sel;
    logic [6:0]            prev_seg;
    logic [NUM_DIGITS-1:0] captured;
    logic [NUM_DIGITS-1:0] sel_low;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  pair_ok;
    logic                  same;
    logic                  blank;
    logic                  commit;
    logic [3:0]            nibble;
    logic                  glyph_err;

`ifdef SEGMENT_READER_CHANGE_ONLY_EN
    logic [4*NUM_DIGITS-1:0] last_value;
    logic [NUM_DIGITS-1:0]   last_err;
`endif

    always_comb begin
        sel_low  = ~digit_sel_ni;
        pair_ok  = (sel_low != '0) && ((sel_low & (sel_low - NUM_DIGITS'(1))) == '0);
        same     = ({digit_sel_ni, segments_ni} == {prev_sel, prev_seg});
        blank    = (segments_ni == 7'h7F);
        cnt_next = CW'(1);
        if (!pair_ok) begin
            cnt_next = '0;
        end else if (same) begin
            cnt_next = (cnt == SAT) ? SAT : cnt + CW'(1);
        end
        // A saturated run must not re-commit, except with a one-sample window.
        commit = pair_ok && !blank && (cnt_next == SAT) &&
                 ((STABLE_CYCLES == 1) || (cnt != SAT)) &&
                 !valid_o && !(&captured);
    end

    always_comb begin
        nibble    = 4'h0;
        glyph_err = 1'b0;
        case (segments_ni)
            7'h40: nibble = 4'h0;
            7'h79: nibble = 4'h1;
            7'h24: nibble = 4'h2;
            7'h30: nibble = 4'h3;
            7'h19: nibble = 4'h4;
            7'h12: nibble = 4'h5;
            7'h02: nibble = 4'h6;
            7'h78: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h10: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h03: nibble = 4'hB;
            7'h46: nibble = 4'hC;
            7'h21: nibble = 4'hD;
            7'h06: nibble = 4'hE;
            7'h0E: nibble = 4'hF;
            default: glyph_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_sel    <= '0;
            prev_seg    <= '0;
            cnt         <= '0;
            captured    <= '0;
            valid_o     <= 1'b0;
            value_o     <= '0;
            digit_err_o <= '0;
`ifdef SEGMENT_READER_CHANGE_ONLY_EN
            last_value  <= '0;
            last_err    <= '0;
`endif
        end else begin
            prev_sel <= digit_sel_ni;
            prev_seg <= segments_ni;
            cnt      <= cnt_next;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (commit && sel_low[i]) begin
                    value_o[4*i +: 4] <= nibble;
                    digit_err_o[i]    <= glyph_err;
                    captured[i]       <= 1'b1;
                end
            end
            if (valid_o) begin
                if (ready_i) begin
                    valid_o  <= 1'b0;
                    captured <= '0;
`ifdef SEGMENT_READER_CHANGE_ONLY_EN
                    last_value <= value_o;
                    last_err   <= digit_err_o;
`endif
                end
            end else if (&captured) begin
`ifdef SEGMENT_READER_CHANGE_ONLY_EN
                if ({value_o, digit_err_o} == {last_value, last_err}) begin
                    captured <= '0;
                end else begin
                    valid_o <= 1'b1;
                end
`else
                valid_o <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed scans plus randomized bus traffic
// compared against a run-length / frame-level reference model.
module tb_segment_reader;

    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned STABLE_CYCLES = 8;
`ifdef SEGMENT_READER_CHANGE_ONLY_EN
    localparam bit CHANGE_ONLY = 1'b1;
`else
    localparam bit CHANGE_ONLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  sel = 4'hF;
    logic        rdy = 1'b0;
    logic        valid;
    logic [15:0] value;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [15:0] m_value = '0;
    logic [3:0]  m_err   = '0;
    logic [3:0]  m_cap   = '0;
    logic [19:0] m_acc   = '0;
    logic [10:0] m_last_pair = '0;
    int          m_run   = 0;

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    segment_reader #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
        .clk_i(clk), .rst_i(rst), .segments_ni(seg), .digit_sel_ni(sel),
        .ready_i(rdy), .valid_o(valid), .value_o(value), .digit_err_o(err)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        logic [10:0] pair;
        int          k;
        logic [3:0]  nib;
        logic        e;
        @(posedge clk);
        pair = {sel, seg};
        if (rst) begin
            m_valid = 0; m_value = '0; m_err = '0; m_cap = '0; m_acc = '0;
            m_last_pair = '0; m_run = 0;
        end else begin
            m_run = (pair == m_last_pair) ? m_run + 1 : 1;
            m_last_pair = pair;
            if (m_valid) begin
                if (rdy) begin
                    m_valid = 0; m_cap = '0; m_acc = {m_value, m_err};
                end
            end else if (m_cap == 4'hF) begin
                if (CHANGE_ONLY && ({m_value, m_err} == m_acc)) m_cap = '0;
                else m_valid = 1;
            end else if ($countones(~sel) == 1 && seg != 7'h7F &&
                         (STABLE_CYCLES == 1 || m_run == STABLE_CYCLES)) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (!sel[i]) k = i;
                nib = 4'h0; e = 1'b1;
                for (int g = 0; g < 16; g++) if (glyphs[g] == seg) begin nib = 4'(g); e = 1'b0; end
                m_value[4*k +: 4] = nib;
                m_err[k] = e;
                m_cap[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; sel = 4'hF; seg = 7'h7F; rdy = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; sel = 4'b1110; seg = 7'h79; rdy = 1;
        tick(); tick();
        rst = 0;
        checks++;
        if ({valid, value, err} !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b val=%h err=%b, want all zero", valid, value, err);
        end
        sel = 4'hF; seg = 7'h7F;
        for (int c = 0; c < 50; c++) begin
            rdy = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (valid !== 1'b0 || value !== 16'h0000) begin
                errors++;
                $display("FAIL idle_blank c=%0d: got v=%0b val=%h, want v=0 val=0000", c, valid, value);
            end
        end
    endtask

    task automatic test_scan(input int hold, input logic [6:0] p0, input logic [6:0] p1,
                             input logic [6:0] p2, input logic [6:0] p3,
                             input int exp_pulses, input int exp_cyc, input logic [15:0] exp_val);
        logic [6:0]  pats [4];
        int          pulses = 0;
        int          pulse_cyc = -1;
        logic        was = 1'b0;
        logic [15:0] pval = '0;
        pats = '{p0, p1, p2, p3};
        do_reset();
        rdy = 1;
        for (int c = 1; c <= 4*hold + 8; c++) begin
            if (c <= 4*hold) begin
                sel = ~(4'(1) << ((c-1)/hold)); seg = pats[(c-1)/hold];
            end else begin
                sel = 4'hF; seg = 7'h7F;
            end
            tick();
            if (valid && !was) begin pulses++; pulse_cyc = c; pval = value; end
            was = valid;
            checks++;
            if ({valid, value, err} !== {m_valid, m_value, m_err}) begin
                errors++;
                $display("FAIL scan_model h=%0d c=%0d: got v=%0b val=%h err=%b, want v=%0b val=%h err=%b",
                         hold, c, valid, value, err, m_valid, m_value, m_err);
            end
        end
        checks++;
        if (pulses != exp_pulses) begin
            errors++;
            $display("FAIL scan_pulses h=%0d: got %0d, want %0d", hold, pulses, exp_pulses);
        end
        if (exp_pulses > 0) begin
            checks++;
            if (pulse_cyc != exp_cyc || pval !== exp_val) begin
                errors++;
                $display("FAIL scan_frame: got cycle %0d val=%h, want cycle %0d val=%h",
                         pulse_cyc, pval, exp_cyc, exp_val);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pats [4];
        pats = '{7'h0E, 7'h7D, 7'h21, 7'h46};
        do_reset();
        rdy = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 32) begin sel = ~(4'(1) << (c/8)); seg = pats[c/8]; end
            else begin sel = 4'hF; seg = 7'h7F; end
            tick();
            checks++;
            if ({valid, value, err} !== {m_valid, m_value, m_err}) begin
                errors++;
                $display("FAIL bp_model c=%0d: got v=%0b val=%h err=%b, want v=%0b val=%h err=%b",
                         c, valid, value, err, m_valid, m_value, m_err);
            end
        end
        checks++;
        if (valid !== 1'b1 || value !== 16'hCD0F || err !== 4'b0010) begin
            errors++;
            $display("FAIL bp_frame: got v=%0b val=%h err=%b, want v=1 val=cd0f err=0010", valid, value, err);
        end
        for (int c = 0; c < 20; c++) begin
            sel = ~(4'(1) << (c/8)); seg = 7'h40;
            tick();
            checks++;
            if (valid !== 1'b1 || value !== 16'hCD0F || err !== 4'b0010) begin
                errors++;
                $display("FAIL bp_hold c=%0d: got v=%0b val=%h err=%b, want v=1 val=cd0f err=0010",
                         c, valid, value, err);
            end
        end
        rdy = 1;
        tick();
        rdy = 0;
        checks++;
        if (valid !== 1'b0 || value !== 16'hCD0F) begin
            errors++;
            $display("FAIL bp_accept: got v=%0b val=%h, want v=0 val=cd0f", valid, value);
        end
    endtask

    task automatic test_invalid_reset();
        do_reset();
        rdy = 0; sel = 4'b1100; seg = 7'h40;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || value !== 16'h0 || err !== 4'h0) begin
                errors++;
                $display("FAIL invalid_sel c=%0d: got v=%0b val=%h err=%b, want all zero", c, valid, value, err);
            end
        end
        sel = 4'b1110; seg = 7'h79;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (value !== 16'h0001) begin
            errors++;
            $display("FAIL pre_reset_commit: got val=%h, want 0001", value);
        end
        sel = 4'b1101; seg = 7'h24;
        for (int c = 0; c < 4; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({valid, value, err} !== 21'h0) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b val=%h err=%b, want all zero", valid, value, err);
        end
    endtask

    task automatic test_change_only();
        logic [6:0]  pats [12];
        int          pulses = 0;
        logic        was = 1'b0;
        pats = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h79, 7'h24, 7'h30, 7'h19, 7'h24, 7'h24, 7'h30, 7'h19};
        do_reset();
        rdy = 1;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 40; c++) begin
                if (c < 32) begin sel = ~(4'(1) << (c/8)); seg = pats[4*s + c/8]; end
                else begin sel = 4'hF; seg = 7'h7F; end
                tick();
                if (valid && !was) pulses++;
                was = valid;
                checks++;
                if ({valid, value, err} !== {m_valid, m_value, m_err}) begin
                    errors++;
                    $display("FAIL change_model s=%0d c=%0d: got v=%0b val=%h, want v=%0b val=%h",
                             s, c, valid, value, m_valid, m_value);
                end
            end
        end
        checks++;
        if (pulses != (CHANGE_ONLY ? 2 : 3)) begin
            errors++;
            $display("FAIL change_pulses: got %0d, want %0d", pulses, CHANGE_ONLY ? 2 : 3);
        end
    endtask

    task automatic test_random();
        int hold;
        int r;
        do_reset();
        for (int h = 0; h < 200; h++) begin
            r = $urandom_range(0, 9);
            if (r < 8) sel = ~(4'(1) << $urandom_range(0, 3));
            else sel = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) seg = glyphs[$urandom_range(0, 15)];
            else if (r == 6) seg = 7'h7F;
            else if (r == 7) seg = 7'h7D;
            else seg = 7'($urandom);
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                rdy = ($urandom_range(0, 3) == 0);
                tick();
                checks++;
                if ({valid, value, err} !== {m_valid, m_value, m_err}) begin
                    errors++;
                    $display("FAIL random h=%0d c=%0d: got v=%0b val=%h err=%b, want v=%0b val=%h err=%b",
                             h, c, valid, value, err, m_valid, m_value, m_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan(8, 7'h79, 7'h24, 7'h30, 7'h19, 1, 33, 16'h4321);
        test_scan(7, 7'h79, 7'h24, 7'h30, 7'h19, 0, 0, 16'h0000);
        test_backpressure();
        test_invalid_reset();
        test_change_only();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
